// File: rtl/encoder_4_to_2_rr.sv
// Registered 4-to-2 request encoder. It picks one winner by fixed or round-robin priority and
// presents it as an index plus a one-hot grant over a valid/ready handshake.
module encoder_4_to_2_rr #(
  parameter int PRIORITY_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] idx,
  output logic [3:0] gnt,
  output logic       multi
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  logic       r_state;
  logic [1:0] r_idx;
  logic [1:0] r_ptr;
  logic       r_multi;

  logic       w_accept;
  logic       w_any_req;
  logic       w_multi_req;
  logic [1:0] w_base;
  logic [1:0] w_start;
  logic [1:0] w_win;

  assign w_accept    = (r_state == S_BUSY) && ready;
  assign w_any_req   = |req;
  assign w_multi_req = |(req & (req - 4'd1));

  // A back-to-back capture searches from the index being accepted, not the stale pointer
  assign w_base  = w_accept ? r_idx : r_ptr;
  assign w_start = (PRIORITY_MODE == 1) ? (w_base + 2'd1) : 2'd0;

  always_comb begin : find_winner
    logic       found;
    logic [1:0] pos;
    found = 1'b0;
    pos   = 2'd0;
    w_win = 2'd0;
    for (int k = 0; k < 4; k++) begin
      pos = w_start + 2'(k);
      if (!found && req[pos]) begin
        w_win = pos;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 2'b00;
      r_ptr   <= 2'b11;
      r_multi <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_idx   <= w_win;
            r_multi <= w_multi_req;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (ready) begin
            r_ptr <= r_idx;
            if (w_any_req) begin
              r_idx   <= w_win;
              r_multi <= w_multi_req;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid = (r_state == S_BUSY);
  assign idx   = r_idx;
  assign multi = r_multi;
  assign gnt   = valid ? (4'b0001 << r_idx) : 4'b0000;

endmodule

// File: tb/tb_encoder_4_to_2_rr.sv
// Directed bench for encoder_4_to_2_rr. It runs a round-robin and a fixed-priority instance
// from shared stimulus, with hand-computed expectations.
module tb_encoder_4_to_2_rr;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ready;

  logic       rr_valid, fp_valid;
  logic [1:0] rr_idx,   fp_idx;
  logic [3:0] rr_gnt,   fp_gnt;
  logic       rr_multi, fp_multi;

  int n_checks;
  int n_errors;

  encoder_4_to_2_rr #(.PRIORITY_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .valid(rr_valid), .idx(rr_idx), .gnt(rr_gnt), .multi(rr_multi)
  );

  encoder_4_to_2_rr #(.PRIORITY_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .valid(fp_valid), .idx(fp_idx), .gnt(fp_gnt), .multi(fp_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rr(input string tag, input logic v, input logic [1:0] i,
                        input logic [3:0] g, input logic m);
    chk({tag, "_valid"}, 8'(rr_valid), 8'(v));
    chk({tag, "_idx"},   8'(rr_idx),   8'(i));
    chk({tag, "_gnt"},   8'(rr_gnt),   8'(g));
    chk({tag, "_multi"}, 8'(rr_multi), 8'(m));
  endtask

  // Mid-cycle reset pulse: asserted between edges, released before the next edge
  task automatic mid_reset();
    #3 rst = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // 1: async reset mid-cycle from BUSY, then idle with no requests
    req = 4'b0001;
    step();
    chk("t1_pre_valid", 8'(rr_valid), 8'd1);
    mid_reset();
    chk_rr("t1_rst", 1'b0, 2'b00, 4'b0000, 1'b0);
    chk("t1_rst_fp_valid", 8'(fp_valid), 8'd0);
    #2 rst = 1'b0;
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t1_idle_valid", 8'(rr_valid), 8'd0);
    end

    // 2: single request, one-cycle latency, then drop
    req = 4'b0100; ready = 1'b1;
    step();
    chk_rr("t2_cap", 1'b1, 2'b10, 4'b0100, 1'b0);
    req = 4'b0000;
    step();
    chk("t2_drop_valid", 8'(rr_valid), 8'd0);
    chk("t2_drop_gnt",   8'(rr_gnt),   8'd0);

    // 3: full request, continuous ready, rotation from a fresh pointer
    mid_reset();
    #2 rst = 1'b0;
    req = 4'b1111; ready = 1'b1;
    step(); chk_rr("t3_c0", 1'b1, 2'b00, 4'b0001, 1'b1);
    step(); chk_rr("t3_c1", 1'b1, 2'b01, 4'b0010, 1'b1);
    step(); chk_rr("t3_c2", 1'b1, 2'b10, 4'b0100, 1'b1);
    step(); chk_rr("t3_c3", 1'b1, 2'b11, 4'b1000, 1'b1);
    step(); chk_rr("t3_c4", 1'b1, 2'b00, 4'b0001, 1'b1);
    req = 4'b0000;
    step();
    chk("t3_end_valid", 8'(rr_valid), 8'd0);

    // 4: backpressure holds the result while req changes
    req = 4'b0010; ready = 1'b0;
    step();
    chk_rr("t4_cap", 1'b1, 2'b01, 4'b0010, 1'b0);
    req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_rr("t4_hold", 1'b1, 2'b01, 4'b0010, 1'b0);
    end
    ready = 1'b1;
    step();
    chk_rr("t4_next", 1'b1, 2'b11, 4'b1000, 1'b0);
    req = 4'b0000;
    step();
    chk("t4_end_valid", 8'(rr_valid), 8'd0);

    // 5: fixed priority keeps granting the lowest set bit
    req = 4'b1010; ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_fp_valid", 8'(fp_valid), 8'd1);
      chk("t5_fp_idx",   8'(fp_idx),   8'd1);
      chk("t5_fp_gnt",   8'(fp_gnt),   8'b0010);
      chk("t5_fp_multi", 8'(fp_multi), 8'd1);
    end
    req = 4'b1000;
    step();
    chk("t5_fp_idx3",   8'(fp_idx),   8'd3);
    chk("t5_fp_multi0", 8'(fp_multi), 8'd0);
    req = 4'b0000;
    step();
    chk("t5_end_valid", 8'(fp_valid), 8'd0);

    // 6: reset during BUSY restores the pointer so the search restarts at index 0
    req = 4'b0011; ready = 1'b0;
    step();
    chk_rr("t6_cap0", 1'b1, 2'b00, 4'b0001, 1'b1);
    ready = 1'b1;
    step();
    chk_rr("t6_cap1", 1'b1, 2'b01, 4'b0010, 1'b1);
    mid_reset();
    chk("t6_rst_valid", 8'(rr_valid), 8'd0);
    chk("t6_rst_gnt",   8'(rr_gnt),   8'd0);
    #2 rst = 1'b0;
    step();
    chk_rr("t6_first", 1'b1, 2'b00, 4'b0001, 1'b1);
    step();
    chk_rr("t6_second", 1'b1, 2'b01, 4'b0010, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
